sd_spi_master: RTL and testbench
================================

// Module: sd_spi_master
// PURPOSE
//  CPU-facing SPI master for the SD-card slot, behind the Zorro II SD window (sdcard_access decode).
//  Byte-wide register file, 68000 DTACK handshake with stall-while-busy, SPI mode-0 shifter with
//  programmable SCLK divider, card-detect debounce and change interrupt on INT2_n.
// PARAMETERS
//  DIV_W      8        width of SCLK divider register
//  DEB_CYCLES 16'd4096 CLKCPU cycles SD_CD_n must be stable before cd_state updates
//  DIV_RESET  8'd9     divider after reset (slow clock for card init)
// PORTS
//  CLKCPU     in   1   CPU clock (7 MHz or turbo); all logic on posedge
//  RESET_n    in   1   asynchronous, active-low reset
//  ACCESS     in   1   SD window decoded and AS_CPU_n low
//  AS_CPU_n   in   1   CPU address strobe
//  DS_n       in   1   UDS_n & LDS_n combined
//  RW_n       in   1   1 = read
//  ADDR       in   4   A[4:1]; register index
//  D_IN       in   16  CPU data; registers use D_IN[7:0]
//  DATA_OUT   out  16  {8'h00, reg byte}
//  DATA_OE    out  1   drive D bus
//  DTACK_n    out  1   active-low acknowledge; high when not selected
//  MISO/CD_n  in   1   SD data-in / card-detect (async, low = card present)
//  SCLK/MOSI  out  1   SPI clock / data-out
//  SS_n       out  1   chip select
//  INT2_n     out  1   active-low interrupt request
// BEHAVIOUR
//  Reset: SCLK=0, MOSI=1, SS_n=1, DTACK_n=1, DATA_OE=0, INT2_n=1, DATA_OUT=0, div=DIV_RESET,
//   rx=8'hFF, busy=0, int_en=0, cd_chg=0, cd_state=sync(CD_n). Reset mid-transfer aborts immediately.
//  Registers (ADDR): 0 DATA  W: load tx, start transfer; R: last rx byte
//   1 STATUS R: {4'b0,cd_chg,int_en,~cd_state,busy}; W: bit3=1 clears cd_chg, bit2 sets int_en
//   2 CTRL   R/W: bit0 = SS_n level (reset 1)
//   3 DIV    R/W: SCLK half-period = DIV+1 CLKCPU cycles; 4-15 read 8'h00, writes ignored.
//  Handshake: cycle = ACCESS & !DS_n. DTACK_n falls on the 2nd posedge of the cycle (1 wait state),
//   except ADDR=0 access while busy: DTACK_n held high until busy=0, then falls next posedge.
//   A write commits exactly once, on the edge DTACK_n falls. DTACK_n, DATA_OE return high
//   asynchronously-fast: combinationally gated by AS_CPU_n (no stretch into next cycle).
//  DATA_OE = cycle & RW_n; DATA_OUT registered, valid by DTACK_n fall.
//  SPI shifter FSM: IDLE -> LOW -> HIGH -> (bit<7 ? LOW : DONE) -> IDLE.
//   IDLE: SCLK=0, MOSI=1. DATA write: busy=1, MOSI=tx[7], bit=0, enter LOW.
//   LOW: hold div+1 cycles, SCLK 0->1, sample MISO into rx shift reg, enter HIGH.
//   HIGH: hold div+1 cycles, SCLK 1->0, shift next tx bit to MOSI. DONE: rx latched, busy=0.
//   MSB first, 8 bits, 16*(div+1) cycles per byte. DIV write during busy takes effect next byte.
//   SS_n purely register-driven; deasserting mid-byte does not abort the shifter.
//  Card detect: 2-FF synchroniser; counter restarts on any sync change; after DEB_CYCLES stable,
//   cd_state updates and cd_chg sets. cd_chg set and STATUS clear-write on same edge: set wins.
//  INT2_n = !(cd_chg & int_en), registered. Divider counter width DIV_W, no wrap beyond DIV.
// STRUCTURE
//  Shared package sd_pkg: register index constants REG_DATA..REG_DIV, STATUS bit positions,
//   FSM state encoding (2-bit), DIV_RESET. One sub-module: sd_cd_debounce (sync+counter+change pulse).
//  Top holds register file, DTACK logic and shifter FSM.
// TESTING
//  1 Reset: all outputs at reset values; read DIV -> 8'h09, STATUS -> busy=0, int_en=0.
//  2 Write DATA=8'hA5, DIV=0, MISO loopback: 8 SCLK rises over 16 cycles, MOSI 1,0,1,0,0,1,0,1; read DATA -> A5.
//  3 Read DATA while busy (DIV=3): DTACK_n high until busy=0, then low; returned byte = completed rx.
//  4 Back-to-back DATA writes 8'h00,8'hFF: second write stalls, no byte lost; MOSI sequence intact.
//  5 CD_n glitch shorter than DEB_CYCLES -> no cd_chg; stable low with int_en=1 -> INT2_n low;
//    write STATUS 8'h08 -> INT2_n high next cycle.
//  6 Assert RESET_n low mid-byte: SCLK=0, SS_n=1, busy=0 immediately; new transfer after reset completes.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants for the SD-card SPI master: register map, STATUS bit layout,
// shifter state encoding and the post-reset SCLK divider.
package sd_pkg;
  localparam logic [3:0] REG_DATA   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_DIV    = 4'd3;

  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_CARD   = 1;
  localparam int unsigned STAT_INT_EN = 2;
  localparam int unsigned STAT_CD_CHG = 3;

  localparam logic [7:0] SD_DIV_RESET = 8'd9;

  typedef enum logic [1:0] {
    SPI_IDLE = 2'd0,
    SPI_LOW  = 2'd1,
    SPI_HIGH = 2'd2,
    SPI_DONE = 2'd3
  } spi_state_t;
endpackage

// File: rtl/sd_cd_debounce.sv
// Card-detect conditioning: 2-FF synchroniser, stability counter, one-cycle change pulse.
// cd_state is primed from the pin right after reset without raising a change.
module sd_cd_debounce #(
  parameter logic [15:0] DEB_CYCLES = 16'd4096
) (
  input  logic CLKCPU,
  input  logic RESET_n,
  input  logic cd_n,
  output logic cd_state,
  output logic cd_chg_pulse
);
  logic        s1, s2, s3;
  logic [15:0] cnt;
  logic [1:0]  prime;

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      s1           <= 1'b1;
      s2           <= 1'b1;
      s3           <= 1'b1;
      cnt          <= 16'd0;
      prime        <= 2'd0;
      cd_state     <= 1'b1;
      cd_chg_pulse <= 1'b0;
    end else begin
      s1           <= cd_n;
      s2           <= s1;
      s3           <= s2;
      cd_chg_pulse <= 1'b0;
      if (prime != 2'd3) begin
        // follow the synchroniser silently until it holds the real pin level
        prime    <= prime + 2'd1;
        cd_state <= s2;
        cnt      <= 16'd0;
      end else if ((s2 != s3) || (s2 == cd_state)) begin
        cnt <= 16'd0;
      end else if (cnt == DEB_CYCLES - 16'd1) begin
        cd_state     <= s2;
        cd_chg_pulse <= 1'b1;
        cnt          <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

// File: rtl/sd_spi_master.sv
// CPU-facing SD SPI master: byte register file, 68000 DTACK handshake that stalls DATA
// accesses while a byte is in flight, mode-0 shifter with programmable SCLK divider, CD interrupt.
module sd_spi_master
  import sd_pkg::*;
#(
  parameter int unsigned      DIV_W      = 8,
  parameter logic [15:0]      DEB_CYCLES = 16'd4096,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(SD_DIV_RESET)
) (
  input  logic        CLKCPU,
  input  logic        RESET_n,
  input  logic        ACCESS,
  input  logic        AS_CPU_n,
  input  logic        DS_n,
  input  logic        RW_n,
  input  logic [3:0]  ADDR,
  input  logic [15:0] D_IN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        DTACK_n,
  input  logic        MISO,
  input  logic        CD_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        SS_n,
  output logic        INT2_n
);
  logic             cycle, stall, fire, wr_en, wr_status;
  logic             seen_q, ack_q;
  logic [DIV_W-1:0] div_q, div_lat, cnt;
  logic             ss_q, int_en_q, cd_chg_q, busy_q, int2_n_q, sclk_q, mosi_q;
  logic             int_en_nxt, cd_chg_nxt;
  logic [7:0]       rx_q, rx_sh, tx_sh, rd_byte;
  logic [15:0]      data_out_q;
  logic [2:0]       bit_cnt;
  logic             cd_state, cd_pulse;
  spi_state_t       state;
  logic             unused_hi;

  assign unused_hi = &{1'b0, D_IN[15:8]};

  assign cycle     = ACCESS & ~DS_n;
  assign stall     = (ADDR == REG_DATA) & busy_q;
  assign fire      = cycle & seen_q & ~ack_q & ~stall;
  assign wr_en     = fire & ~RW_n;
  assign wr_status = wr_en & (ADDR == REG_STATUS);

  // Strobe gating releases the bus as soon as the CPU ends the cycle.
  assign DTACK_n  = ~(ack_q & cycle & ~AS_CPU_n);
  assign DATA_OE  = cycle & RW_n & ~AS_CPU_n;
  assign DATA_OUT = data_out_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign SS_n     = ss_q;
  assign INT2_n   = int2_n_q;

  sd_cd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cd (
    .CLKCPU       (CLKCPU),
    .RESET_n      (RESET_n),
    .cd_n         (CD_n),
    .cd_state     (cd_state),
    .cd_chg_pulse (cd_pulse)
  );

  always_comb begin
    rd_byte = 8'h00;
    case (ADDR)
      REG_DATA: rd_byte = rx_q;
      REG_STATUS: begin
        rd_byte[STAT_BUSY]   = busy_q;
        rd_byte[STAT_CARD]   = ~cd_state;
        rd_byte[STAT_INT_EN] = int_en_q;
        rd_byte[STAT_CD_CHG] = cd_chg_q;
      end
      REG_CTRL: rd_byte = {7'd0, ss_q};
      REG_DIV:  rd_byte = 8'(div_q);
      default:  rd_byte = 8'h00;
    endcase
  end

  // A fresh card-detect change beats a simultaneous clear from the CPU.
  always_comb begin
    int_en_nxt = wr_status ? D_IN[STAT_INT_EN] : int_en_q;
    cd_chg_nxt = cd_chg_q;
    if (wr_status && D_IN[STAT_CD_CHG]) cd_chg_nxt = 1'b0;
    if (cd_pulse) cd_chg_nxt = 1'b1;
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      seen_q     <= 1'b0;
      ack_q      <= 1'b0;
      data_out_q <= 16'h0000;
      div_q      <= DIV_RESET;
      ss_q       <= 1'b1;
      int_en_q   <= 1'b0;
      cd_chg_q   <= 1'b0;
      int2_n_q   <= 1'b1;
    end else begin
      if (!cycle) begin
        seen_q <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        seen_q <= 1'b1;
        if (fire) ack_q <= 1'b1;
        if (fire && RW_n) data_out_q <= {8'h00, rd_byte};
      end
      if (wr_en && ADDR == REG_CTRL) ss_q  <= D_IN[0];
      if (wr_en && ADDR == REG_DIV)  div_q <= D_IN[DIV_W-1:0];
      int_en_q <= int_en_nxt;
      cd_chg_q <= cd_chg_nxt;
      int2_n_q <= ~(cd_chg_nxt & int_en_nxt);
    end
  end

  // Divider is latched at byte start so a DIV write mid-byte applies to the next byte.
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state   <= SPI_IDLE;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      tx_sh   <= 8'h00;
      rx_sh   <= 8'hFF;
      rx_q    <= 8'hFF;
      cnt     <= '0;
      div_lat <= DIV_RESET;
      bit_cnt <= 3'd0;
    end else begin
      case (state)
        SPI_IDLE: begin
          if (wr_en && ADDR == REG_DATA) begin
            busy_q  <= 1'b1;
            tx_sh   <= D_IN[7:0];
            mosi_q  <= D_IN[7];
            bit_cnt <= 3'd0;
            cnt     <= '0;
            div_lat <= div_q;
            state   <= SPI_LOW;
          end
        end
        SPI_LOW: begin
          if (cnt == div_lat) begin
            cnt    <= '0;
            sclk_q <= 1'b1;
            rx_sh  <= {rx_sh[6:0], MISO};
            state  <= SPI_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SPI_HIGH: begin
          if (cnt == div_lat) begin
            cnt    <= '0;
            sclk_q <= 1'b0;
            if (bit_cnt == 3'd7) begin
              state <= SPI_DONE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
              mosi_q  <= tx_sh[6];
              state   <= SPI_LOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SPI_DONE: begin
          rx_q   <= rx_sh;
          busy_q <= 1'b0;
          mosi_q <= 1'b1;
          state  <= SPI_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sd_spi_master.sv
// Directed + randomized bench for sd_spi_master: bus-level register accesses, SPI bytes
// checked against a bit-list model of MSB-first mode-0 transfers, card-detect and reset.
`timescale 1ns/1ps
module tb_sd_spi_master;
  import sd_pkg::*;

  localparam int PER = 10;
  localparam int DEB = 64;

  logic        CLKCPU = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ACCESS = 1'b0, AS_CPU_n = 1'b1, DS_n = 1'b1, RW_n = 1'b1;
  logic [3:0]  ADDR = 4'd0;
  logic [15:0] D_IN = 16'h0000;
  logic [15:0] DATA_OUT;
  logic        DATA_OE, DTACK_n, MISO, SCLK, MOSI, SS_n, INT2_n;
  logic        CD_n = 1'b1;

  int   n_pass = 0, n_chk = 0, last_ws = 0, rbase = 0, rise_cnt = 0;
  logic loopback = 1'b1;
  logic [7:0] miso_byte = 8'h00;
  bit   mosi_q[$];
  time  rise_t[$];

  always #(PER/2) CLKCPU = ~CLKCPU;

  // Slave model: either echoes MOSI or presents miso_byte MSB first, advancing after each rise.
  assign MISO = loopback ? MOSI : miso_byte[3'(7 - (rise_cnt - rbase))];

  always @(posedge SCLK) begin
    mosi_q.push_back(MOSI);
    rise_t.push_back($time);
    rise_cnt++;
  end

  sd_spi_master #(.DEB_CYCLES(16'(DEB))) dut (
    .CLKCPU(CLKCPU), .RESET_n(RESET_n), .ACCESS(ACCESS), .AS_CPU_n(AS_CPU_n),
    .DS_n(DS_n), .RW_n(RW_n), .ADDR(ADDR), .D_IN(D_IN), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE), .DTACK_n(DTACK_n), .MISO(MISO), .CD_n(CD_n), .SCLK(SCLK),
    .MOSI(MOSI), .SS_n(SS_n), .INT2_n(INT2_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic bus(input logic rw, input logic [3:0] a, input logic [7:0] wd,
                     input int exp_ws, output logic [7:0] rd);
    int ws;
    @(negedge CLKCPU);
    ACCESS = 1'b1; AS_CPU_n = 1'b0; DS_n = 1'b0; RW_n = rw; ADDR = a; D_IN = {8'h00, wd};
    ws = 0;
    while (DTACK_n !== 1'b0 && ws < 3000) begin
      @(negedge CLKCPU);
      ws++;
    end
    check("dtack_ack", 32'(DTACK_n), 0);
    if (exp_ws >= 0) check("wait_states", ws, exp_ws);
    last_ws = ws;
    rd = DATA_OUT[7:0];
    if (rw) check("rd_upper_zero", 32'(DATA_OUT[15:8]), 0);
    check("data_oe", 32'(DATA_OE), 32'(rw));
    ACCESS = 1'b0; AS_CPU_n = 1'b1; DS_n = 1'b1;
    #1 check("dtack_release", 32'(DTACK_n), 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input int ews);
    logic [7:0] unused_rd;
    bus(1'b0, a, d, ews, unused_rd);
  endtask

  task automatic rd(input logic [3:0] a, input int ews, output logic [7:0] d);
    bus(1'b1, a, 8'h00, ews, d);
  endtask

  function automatic logic [7:0] mosi_byte(input int base);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], logic'(mosi_q[base + i])};
    return b;
  endfunction

  // One byte: expected MOSI = tx MSB first, rx = echoed tx or slave byte, SCLK period 2*(div+1).
  task automatic run_byte(input logic [7:0] tx, input logic [7:0] dv, input logic lb,
                          input logic [7:0] mb);
    int qb;
    logic [7:0] got;
    wr(REG_DIV, dv, 2);
    loopback = lb; miso_byte = mb; qb = mosi_q.size(); rbase = rise_cnt;
    wr(REG_DATA, tx, 2);
    rd(REG_DATA, -1, got);
    check("data_stall", 32'(last_ws >= 14 * (int'(dv) + 1)), 1);
    check("rx_byte", 32'(got), 32'(lb ? tx : mb));
    check("sclk_rises", mosi_q.size() - qb, 8);
    check("mosi_bits", 32'(mosi_byte(qb)), 32'(tx));
    check("sclk_period", 32'((rise_t[qb + 7] - rise_t[qb]) / PER), 14 * (int'(dv) + 1));
  endtask

  initial begin
    #(PER * 5000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int qb, cyc;

    // Reset values
    repeat (3) @(negedge CLKCPU);
    check("rst_sclk", 32'(SCLK), 0);
    check("rst_mosi", 32'(MOSI), 1);
    check("rst_ss_n", 32'(SS_n), 1);
    check("rst_dtack", 32'(DTACK_n), 1);
    check("rst_oe", 32'(DATA_OE), 0);
    check("rst_int2", 32'(INT2_n), 1);
    check("rst_dout", 32'(DATA_OUT), 0);
    RESET_n = 1'b1;
    repeat (4) @(negedge CLKCPU);
    rd(REG_DIV, 2, v);    check("rst_div", 32'(v), 32'h09);
    rd(REG_STATUS, 2, v); check("rst_status", 32'(v), 32'h00);
    rd(REG_DATA, 2, v);   check("rst_rx", 32'(v), 32'hFF);
    rd(4'd7, 2, v);       check("unmapped_rd", 32'(v), 32'h00);

    wr(REG_CTRL, 8'h00, 2);
    check("ss_low", 32'(SS_n), 0);

    // Fast loopback, stalled DATA read with slave data, then randomized bytes
    run_byte(8'hA5, 8'd0, 1'b1, 8'h00);
    run_byte(8'($urandom), 8'd3, 1'b0, 8'($urandom));
    for (int i = 0; i < 4; i++)
      run_byte(8'($urandom), 8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Back-to-back DATA writes: second one stalls, both bytes go out intact
    wr(REG_DIV, 8'd1, 2);
    loopback = 1'b1; qb = mosi_q.size();
    wr(REG_DATA, 8'h00, 2);
    wr(REG_DATA, 8'hFF, -1);
    check("b2b_stalled", 32'(last_ws > 2), 1);
    rd(REG_DATA, -1, v);
    check("b2b_rx", 32'(v), 32'hFF);
    check("b2b_rises", mosi_q.size() - qb, 16);
    check("b2b_first", 32'(mosi_byte(qb)), 32'h00);
    check("b2b_second", 32'(mosi_byte(qb + 8)), 32'hFF);

    // Card detect: short glitch ignored, stable insertion raises INT2_n, clear drops it
    wr(REG_STATUS, 8'h04, 2);
    @(negedge CLKCPU); CD_n = 1'b0;
    repeat (DEB / 3) @(negedge CLKCPU);
    CD_n = 1'b1;
    repeat (DEB + 20) @(negedge CLKCPU);
    rd(REG_STATUS, 2, v);
    check("glitch_status", 32'(v), 32'h04);
    check("glitch_int2", 32'(INT2_n), 1);
    CD_n = 1'b0; cyc = 0;
    while (INT2_n !== 1'b0 && cyc < 4 * DEB) begin
      @(negedge CLKCPU);
      cyc++;
    end
    check("cd_int2_low", 32'(INT2_n), 0);
    check("cd_debounced", 32'(cyc >= DEB), 1);
    rd(REG_STATUS, 2, v);
    check("cd_status", 32'(v), 32'h0E);
    wr(REG_STATUS, 8'h08, 2);
    @(negedge CLKCPU);
    check("cd_clear_int2", 32'(INT2_n), 1);
    rd(REG_STATUS, 2, v);
    check("cd_cleared", 32'(v & 8'h0B), 32'h02);

    // Reset mid-byte aborts; a new transfer afterwards completes
    wr(REG_DIV, 8'd7, 2);
    wr(REG_DATA, 8'h3C, 2);
    repeat (30) @(negedge CLKCPU);
    rd(REG_STATUS, 2, v);
    check("midbyte_busy", 32'(v[0]), 1);
    RESET_n = 1'b0;
    #1;
    check("abort_sclk", 32'(SCLK), 0);
    check("abort_ss_n", 32'(SS_n), 1);
    check("abort_mosi", 32'(MOSI), 1);
    repeat (2) @(negedge CLKCPU);
    RESET_n = 1'b1;
    repeat (4) @(negedge CLKCPU);
    rd(REG_STATUS, 2, v);
    check("abort_busy", 32'(v[0]), 0);
    rd(REG_DIV, 2, v);
    check("abort_div", 32'(v), 32'h09);
    run_byte(8'($urandom), 8'd9, 1'b1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
